uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_period  input  16  bit length in clk cycles; supported range 8..65535.
REQ-005 SHALL have port serial_in  input  1  asynchronous UART line; idles high.
REQ-006 SHALL have port data  output  8  byte at the FIFO head; valid only while rx_valid.
REQ-007 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts the head byte.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: byte dropped because FIFO full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-012 SHALL pass serial_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-014 IDLE: a synchronized low SHALL move to START, latch bit_period, and load the counter with bit_period/2 (floor).
REQ-015 START: at counter expiry the line SHALL be resampled; low -> DATA with counter = bit_period; high -> IDLE as a glitch, with no outputs.
REQ-016 DATA: SHALL sample 8 bits, one per bit_period, LSB first, into a shift register.
REQ-017 STOP: high sample -> push byte and enter IDLE; low sample -> frame_err pulse, discard byte, enter BREAK.
REQ-018 BREAK: SHALL stay until line sampled high, then IDLE; no new start is detected while in BREAK.
REQ-019 A bit_period change mid-frame SHALL be ignored until the next start detection.
REQ-020 The push SHALL occur in the stop-sample cycle; rx_valid SHALL rise the following cycle when the FIFO was empty.
REQ-021 A pop SHALL occur when rx_valid && rx_ready; data SHALL show the next entry the cycle after the pop.
REQ-022 Push into a full FIFO SHALL drop the new byte and pulse overrun; contents remain unchanged.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full, with no overrun.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL hold FIFO_DEPTH without aliasing to empty.
REQ-025 Error pulses SHALL be exactly one cycle; frame_err and overrun never assert for the same frame.

Reset
REQ-026 nrst low SHALL asynchronously force state IDLE, synchronizer flops to 1, counters, shift register and FIFO pointers to 0, and rx_valid, frame_err, overrun, parity_err to 0; data SHALL read 0x00.
REQ-027 Reset mid-frame SHALL discard the partial byte and all FIFO contents; after release, reception SHALL begin only on a fresh falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL follow bit 7 in state PARITY; on mismatch parity_err SHALL pulse in the stop-sample cycle and the byte SHALL be discarded; STOP handling is otherwise unchanged.
REQ-029 Macro UART_RX_PARITY_EN undefined: frame SHALL be 8N1, there SHALL be no PARITY state, and parity_err SHALL be constant 0.

Verification
REQ-030 uart_tx at bit_period=104 sends 0xA5 -> rx_valid rises 1 cycle after the stop sample, about 990 cycles after the start edge; data=0xA5; no error pulses.
REQ-031 serial_in low for 30 cycles then high, bit_period=104 -> no rx_valid and no error pulses; a 0x3C sent next is received correctly.
REQ-032 Frame 0x55 with stop bit forced low for 104 cycles, then line high -> single frame_err pulse; FIFO stays empty; a following 0x81 is received.
REQ-033 FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> overrun pulses once on 0x05; popping yields 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
REQ-034 FIFO full, rx_ready=1 held during the stop sample of 0x06 -> no overrun; pops yield 0x02..0x04 then 0x06.
REQ-035 nrst pulsed during bit 3 of 0xF0, then 0x0F sent -> only 0x0F is received; with UART_RX_PARITY_EN, 0x0F sent with parity bit 1 -> parity_err pulses and no byte is pushed.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side byte stream of uart_rx: head-of-FIFO data with a valid/ready handshake.
// master = uart_rx (producer), slave = consumer.
interface uart_rx_if;
    logic [7:0] data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default (8E1 when UART_RX_PARITY_EN is defined), with a small
// receive FIFO. The bit length is programmable and is captured at each start detection.
module uart_rx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] bit_period,
    input  logic        serial_in,
    uart_rx_if.master   rx_if,
    output logic        frame_err,
    output logic        overrun,
    output logic        parity_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DepthCnt = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        rx_prev_q;
    logic [1:0]  settle_q;
    logic [15:0] period_q, period_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx, start_edge, expire, push;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic        full, pop, wr_en;

    assign rx     = sync2_q;
    assign expire = (cnt_q <= 16'd1);
    // rx_prev_q stays 0 until the synchronizer holds real line values, so a line that is
    // already low when reset releases is not mistaken for a start bit.
    assign start_edge = !rx && rx_prev_q;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        cnt_d     = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_err = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d  = StStart;
                    period_d = bit_period;
                    cnt_d    = {1'b0, bit_period[15:1]};
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            StStart: begin
                if (expire) begin
                    if (!rx) begin
                        state_d   = StData;
                        cnt_d     = period_q;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (expire) begin
                    shift_d   = {rx, shift_q[7:1]};
                    cnt_d     = period_q;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (expire) begin
                    par_bad_d = rx ^ (^shift_q);
                    cnt_d     = period_q;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (expire) begin
`ifdef UART_RX_PARITY_EN
                    parity_err = par_bad_q;
`endif
                    if (rx) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = StIdle;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b0;
            settle_q  <= 2'd0;
            period_q  <= 16'd0;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            rx_prev_q <= (settle_q == 2'd2) && rx;
            settle_q  <= (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // A pop in the push cycle frees a slot, so a full FIFO still accepts the byte.
    assign full           = (count_q == DepthCnt);
    assign rx_if.rx_valid = (count_q != '0);
    assign pop            = rx_if.rx_valid && rx_if.rx_ready;
    assign wr_en          = push && (!full || pop);
    assign overrun        = push && full && !pop;
    assign rx_if.data     = rx_if.rx_valid ? mem[rd_ptr_q] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
